// File: rtl/midi_event_sched_pkg.sv
// Shared types and width defaults for the MIDI event scheduler.
package midi_event_sched_pkg;

    localparam int TIME_W_DEF = 16;
    localparam int MIDI_MSG_W = 24;
    localparam int DATA_W_DEF = MIDI_MSG_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        EMIT
    } sched_state_t;

endpackage

// File: rtl/midi_event_fifo.sv
// Synchronous event FIFO with registered storage and an occupancy count.
module midi_event_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/midi_event_scheduler.sv
// Releases queued MIDI events after their delta-ms from the previous release.
// Optional synchronous flush input when MIDI_EVENT_SCHED_FLUSH_EN is defined.
module midi_event_scheduler
    import midi_event_sched_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TIME_W = TIME_W_DEF,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TIME_W-1:0] ms_time,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TIME_W-1:0] in_delta,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [LW-1:0]     level
`ifdef MIDI_EVENT_SCHED_FLUSH_EN
    ,
    input  logic              flush
`endif
);

    localparam int FW = TIME_W + DATA_W;

    sched_state_t      state;
    sched_state_t      state_n;
    logic [TIME_W-1:0] delta_r;
    logic [TIME_W-1:0] start_r;
    logic [TIME_W-1:0] elapsed;
    logic [DATA_W-1:0] data_r;
    logic [FW-1:0]     head;
    logic              push;
    logic              pop;
    logic              fire;
    logic              clr;
    logic              empty;

`ifdef MIDI_EVENT_SCHED_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    assign in_ready = (level != LW'(DEPTH)) && !clr;
    assign push     = in_valid && in_ready;
    assign empty    = (level == '0);
    // Modular difference keeps the compare correct across ms_time rollover
    assign elapsed  = ms_time - start_r;
    assign busy     = (state != IDLE) || !empty;

    midi_event_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   ({in_delta, in_data}),
        .dout  (head),
        .level (level)
    );

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        fire    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (elapsed >= delta_r) begin
                    fire    = 1'b1;
                    state_n = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pop     = !empty;
                    state_n = empty ? IDLE : WAIT;
                end
            end
            default: state_n = IDLE;
        endcase
        if (clr) begin
            state_n = IDLE;
            pop     = 1'b0;
            fire    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            delta_r   <= '0;
            data_r    <= '0;
            start_r   <= '0;
        end else begin
            state <= state_n;
            if (pop) begin
                {delta_r, data_r} <= head;
                start_r           <= ms_time;
            end
            if (fire) begin
                out_valid <= 1'b1;
                out_data  <= data_r;
            end else if (clr || (state == EMIT && out_ready)) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_midi_event_scheduler.sv
// Self-checking bench for midi_event_scheduler: vector table plus scoreboard.
module tb_midi_event_scheduler;

    localparam int MS_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ms_time = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_delta = '0;
    logic [23:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_data;
    logic        busy;
    logic [3:0]  level;
`ifdef MIDI_EVENT_SCHED_FLUSH_EN
    logic        flush = 1'b0;
`endif

    always #5 clk = ~clk;

    midi_event_scheduler #(
        .DEPTH  (8),
        .DATA_W (24),
        .TIME_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ms_time   (ms_time),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_delta  (in_delta),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
`ifdef MIDI_EVENT_SCHED_FLUSH_EN
        .flush     (flush),
`endif
        .level     (level)
    );

    typedef struct {
        logic [23:0] data;
        logic [15:0] t;
        bit          chk;
        bit          chain;
    } exp_t;

    typedef struct {
        logic [15:0] ms0;
        logic [15:0] delta;
        logic [15:0] exp_ms;
        logic [23:0] data;
    } vec_t;

    exp_t        sbq[$];
    exp_t        me;
    vec_t        tbl[5];
    int          total = 0;
    int          bad = 0;
    int          n_rel = 0;
    int          ms_cnt = 0;
    int          acc;
    int          n0;
    logic [15:0] last_rel = '0;
    logic [15:0] mdiff;
    bit          prev_hold = 1'b0;
    logic [23:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ms_cnt++;
        if (ms_cnt == MS_DIV) begin
            ms_cnt  = 0;
            ms_time = ms_time + 16'd1;
        end
    endtask

    task automatic sync_ms(input logic [15:0] t);
        ms_time = t;
        ms_cnt  = 0;
    endtask

    task automatic sb_add(input logic [23:0] d, input logic [15:0] t,
                          input bit chk, input bit chain);
        exp_t e;
        e.data  = d;
        e.t     = t;
        e.chk   = chk;
        e.chain = chain;
        sbq.push_back(e);
    endtask

    task automatic push_ev(input logic [15:0] d, input logic [23:0] m,
                           input logic [15:0] t, input bit chk,
                           input bit chain);
        int n = 0;
        in_valid = 1'b1;
        in_delta = d;
        in_data  = m;
        while (!in_ready && n < 500) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got in_ready=0 want 1");
        end else begin
            sb_add(m, t, chk, chain);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            tick();
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=1 want 0");
        end
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!out_valid && n < max) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL valid_timeout: got out_valid=0 want 1");
        end
    endtask

    // Release monitor: order, data, timing window and hold stability
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(out_valid), 1);
                if (out_valid)
                    check("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                n_rel++;
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_release: got %h want none",
                             out_data);
                end else begin
                    me = sbq.pop_front();
                    check("rel_data", 32'(out_data), 32'(me.data));
                    if (me.chk) begin
                        if (me.chain)
                            mdiff = ms_time - last_rel - me.t;
                        else
                            mdiff = ms_time - me.t;
                        total++;
                        if (mdiff > 16'd1) begin
                            bad++;
                            $display("FAIL rel_time: got ms=%0d off=%0d want off 0..1",
                                     ms_time, mdiff);
                        end
                    end
                end
                last_rel = ms_time;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    initial begin
        tbl[0] = '{16'd50,    16'd0, 16'd50,   24'h903C64};
        tbl[1] = '{16'd200,   16'd3, 16'd203,  24'h912040};
        tbl[2] = '{16'd65533, 16'd6, 16'd3,    24'h903C64};
        tbl[3] = '{16'd1000,  16'd1, 16'd1001, 24'hB07B00};
        tbl[4] = '{16'd65535, 16'd1, 16'd0,    24'h80407F};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_out_data", 32'(out_data), 0);

        // delta=0 latency: pushed in cycle N, valid in cycle N+3
        out_ready = 1'b1;
        sync_ms(16'd10);
        push_ev(16'd0, 24'h903C64, 16'd10, 1'b1, 1'b0);
        check("lat_n1", 32'(out_valid), 0);
        tick();
        check("lat_n2", 32'(out_valid), 0);
        tick();
        check("lat_n3", 32'(out_valid), 1);
        check("lat_data", 32'(out_data), 32'h903C64);
        tick();
        check("lat_drop", 32'(out_valid), 0);
        check("lat_busy", 32'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            n0 = n_rel;
            sync_ms(tbl[i].ms0);
            push_ev(tbl[i].delta, tbl[i].data, tbl[i].exp_ms, 1'b1, 1'b0);
            wait_idle(4 * int'(tbl[i].delta) + 40);
            check("vec_count", 32'(n_rel), 32'(n0 + 1));
        end

        // chained deltas 5 then 10 from ms 100
        n0 = n_rel;
        sync_ms(16'd100);
        push_ev(16'd5, 24'h903C64, 16'd105, 1'b1, 1'b0);
        push_ev(16'd10, 24'h803C00, 16'd115, 1'b1, 1'b0);
        wait_idle(200);
        check("seq_count", 32'(n_rel), 32'(n0 + 2));

        // backpressure: next delta counts from the actual release
        n0 = n_rel;
        sync_ms(16'd300);
        out_ready = 1'b0;
        push_ev(16'd2, 24'hC01100, 16'd0, 1'b0, 1'b0);
        push_ev(16'd3, 24'hC02200, 16'd3, 1'b1, 1'b1);
        wait_valid(100);
        for (int i = 0; i < 40; i++) tick();
        out_ready = 1'b1;
        wait_idle(200);
        check("bp_count", 32'(n_rel), 32'(n0 + 2));

        // fill: one event held in the scheduler plus eight in the FIFO
        n0 = n_rel;
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_delta = '0;
            in_data  = 24'hA00000 + 24'(acc);
            if (in_ready) begin
                sb_add(in_data, 16'd0, 1'b0, 1'b0);
                acc++;
            end
            tick();
        end
        check("full_accepted", 32'(acc), 9);
        check("full_level", 32'(level), 8);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_out_valid", 32'(out_valid), 1);
        check("full_out_data", 32'(out_data), 32'hA00000);
        for (int i = 0; i < 5; i++) tick();
        check("full_stall_ready", 32'(in_ready), 0);
        check("full_stall_level", 32'(level), 8);
        out_ready = 1'b1;
        begin
            int n = 0;
            while (!in_ready && n < 50) begin
                tick();
                n++;
            end
        end
        check("full_reopen", 32'(in_ready), 1);
        if (in_ready) begin
            sb_add(in_data, 16'd0, 1'b0, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        wait_idle(300);
        check("full_drain", 32'(n_rel), 32'(n0 + 10));
        check("full_sb_empty", 32'(sbq.size()), 0);

        // reset mid-operation discards everything
        n0 = n_rel;
        sync_ms(16'd500);
        push_ev(16'd20, 24'hE00001, 16'd0, 1'b0, 1'b0);
        push_ev(16'd20, 24'hE00002, 16'd0, 1'b0, 1'b0);
        push_ev(16'd20, 24'hE00003, 16'd0, 1'b0, 1'b0);
        rst = 1'b1;
        sbq.delete();
        tick();
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_data", 32'(out_data), 0);
        rst = 1'b0;
        for (int i = 0; i < 120; i++) tick();
        check("mid_rst_none", 32'(n_rel), 32'(n0));

`ifdef MIDI_EVENT_SCHED_FLUSH_EN
        n0 = n_rel;
        sync_ms(16'd700);
        for (int i = 0; i < 5; i++)
            push_ev(16'd50, 24'hB00000 + 24'(i), 16'd0, 1'b0, 1'b0);
        check("fl_level_pre", 32'(level), 4);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 24'hBFFFFF;
        check("fl_in_ready", 32'(in_ready), 0);
        sbq.delete();
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_level", 32'(level), 0);
        check("fl_valid", 32'(out_valid), 0);
        check("fl_busy", 32'(busy), 0);
        for (int i = 0; i < 300; i++) tick();
        check("fl_none", 32'(n_rel), 32'(n0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
